expr_vector_sequencer: RTL and testbench

Self-checking stimulus stage placed directly upstream of the 3-input expression block (b = (a1|a2) & (a2&a3)). On a start pulse it drives all eight {a1,a2,a3} combinations in ascending order and holds each for a programmable number of cycles. It samples the expression block's output b for every vector and compares it with an internal golden model. It reports per-vector mismatches, a total error count and a final pass/fail verdict, so the lab exercise runs in hardware without a testbench.

---
 rtl/expr_vector_sequencer.sv | 119 +++++++++++
 tb/tb_expr_vector_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/expr_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : expr_vector_sequencer
// Description : Sweeps all eight {a1,a2,a3} vectors into the expression block
//               b = (a1|a2)&(a2&a3), checks b against a golden model and
//               reports per-vector mismatches, an error count and a verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module expr_vector_sequencer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       b,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic [2:0] vec_idx,
   output logic       busy,
   output logic       mismatch,
   output logic [3:0] err_count,
   output logic       done,
   output logic       pass
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_APPLY = 2'd1;
   localparam logic [1:0] c_CHECK = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   // HOLD_CYCLES is at most 256, so the reload value always fits in 8 bits.
   localparam logic [7:0] c_RELOAD = 8'(HOLD_CYCLES - 1);

   logic [1:0] r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_vec;
   logic       r_busy;
   logic       r_mismatch;
   logic [3:0] r_err;
   logic       r_done;
   logic       r_pass;

   logic       w_expected;
   logic       w_fail;
   logic [3:0] w_err_next;

   always_comb begin
      w_expected = (r_vec[2] | r_vec[1]) & (r_vec[1] & r_vec[0]);
      w_fail     = (b != w_expected);
      w_err_next = r_err + {3'b000, w_fail};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_cnt      <= 8'd0;
         r_vec      <= 3'd0;
         r_busy     <= 1'b0;
         r_mismatch <= 1'b0;
         r_err      <= 4'd0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         r_mismatch <= 1'b0;
         case (r_state)
            c_IDLE, c_DONE: begin
               if (start) begin
                  r_state <= c_APPLY;
                  r_vec   <= 3'd0;
                  r_err   <= 4'd0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_cnt   <= c_RELOAD;
               end
            end
            c_APPLY: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_state <= c_CHECK;
               end
            end
            c_CHECK: begin
               if (w_fail) begin
                  r_err      <= w_err_next;
                  r_mismatch <= 1'b1;
               end
               if (r_vec != 3'd7) begin
                  r_vec   <= r_vec + 3'd1;
                  r_cnt   <= c_RELOAD;
                  r_state <= c_APPLY;
               end else begin
                  // Verdict uses the count including this last vector's result.
                  r_state <= c_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == 4'd0);
                  r_vec   <= 3'd0;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign a1        = r_vec[2];
   assign a2        = r_vec[1];
   assign a3        = r_vec[0];
   assign vec_idx   = r_vec;
   assign busy      = r_busy;
   assign mismatch  = r_mismatch;
   assign err_count = r_err;
   assign done      = r_done;
   assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_expr_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_expr_vector_sequencer
// Description : Randomized self-checking bench for expr_vector_sequencer with
//               HOLD_CYCLES=2 and HOLD_CYCLES=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_vector_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       st;
   int         sel;
   logic [7:0] b_tbl;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   logic       start_0, b_0, a1_0, a2_0, a3_0, busy_0, mis_0, done_0, pass_0;
   logic [2:0] vec_0;
   logic [3:0] err_0;
   logic       start_1, b_1, a1_1, a2_1, a3_1, busy_1, mis_1, done_1, pass_1;
   logic [2:0] vec_1;
   logic [3:0] err_1;

   // The downstream block is modelled as a lookup on the driven vector.
   assign start_0 = (sel == 0) ? st : 1'b0;
   assign start_1 = (sel == 1) ? st : 1'b0;
   assign b_0     = b_tbl[{a1_0, a2_0, a3_0}];
   assign b_1     = b_tbl[{a1_1, a2_1, a3_1}];

   expr_vector_sequencer #(.HOLD_CYCLES(2)) u_dut_h2 (
      .clk(clk), .rst_n(rst_n), .start(start_0), .b(b_0),
      .a1(a1_0), .a2(a2_0), .a3(a3_0), .vec_idx(vec_0), .busy(busy_0),
      .mismatch(mis_0), .err_count(err_0), .done(done_0), .pass(pass_0)
   );

   expr_vector_sequencer #(.HOLD_CYCLES(1)) u_dut_h1 (
      .clk(clk), .rst_n(rst_n), .start(start_1), .b(b_1),
      .a1(a1_1), .a2(a2_1), .a3(a3_1), .vec_idx(vec_1), .busy(busy_1),
      .mismatch(mis_1), .err_count(err_1), .done(done_1), .pass(pass_1)
   );

   logic [2:0] o_vec, o_abc;
   logic       o_busy, o_mis, o_done, o_pass;
   logic [3:0] o_err;

   always_comb begin
      if (sel == 1) begin
         o_vec = vec_1; o_abc = {a1_1, a2_1, a3_1}; o_busy = busy_1;
         o_mis = mis_1; o_done = done_1; o_pass = pass_1; o_err = err_1;
      end else begin
         o_vec = vec_0; o_abc = {a1_0, a2_0, a3_0}; o_busy = busy_0;
         o_mis = mis_0; o_done = done_0; o_pass = pass_0; o_err = err_0;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
      end
   endtask

   function automatic bit golden(input int v);
      bit x1, x2, x3;
      x1 = v[2]; x2 = v[1]; x3 = v[0];
      return (x1 | x2) & (x2 & x3);
   endfunction

   function automatic int hold_of(input int s);
      return (s == 1) ? 1 : 2;
   endfunction

   task automatic check_outs(input string tag, input int vec, input int bsy,
                             input int dn, input int ps, input int mis, input int err);
      check({tag, ".vec_idx"}, o_vec, vec);
      check({tag, ".abc"}, o_abc, vec);
      check({tag, ".busy"}, o_busy, bsy);
      check({tag, ".done"}, o_done, dn);
      check({tag, ".pass"}, o_pass, ps);
      check({tag, ".mismatch"}, o_mis, mis);
      check({tag, ".err_count"}, o_err, err);
   endtask

   // mode: 0 correct, 1 tied 0, 2 tied 1, 3 inverted, 4 random
   task automatic fill(input int mode);
      for (int i = 0; i < 8; i++) begin
         case (mode)
            0:       b_tbl[i] = golden(i);
            1:       b_tbl[i] = 1'b0;
            2:       b_tbl[i] = 1'b1;
            3:       b_tbl[i] = ~golden(i);
            default: b_tbl[i] = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic pulse_start(input int s);
      sel = s;
      @(posedge clk); #1 st = 1'b1;
      @(posedge clk); #1 st = 1'b0;
   endtask

   // One full sweep; with noisy=1 start is toggled randomly while busy.
   task automatic run_sweep(input string name, input int s, input bit noisy);
      int  h, len, err, v, vec;
      bit  mis;
      h   = hold_of(s);
      len = 8 * (h + 1);
      err = 0;
      pulse_start(s);
      check_outs({name, ".k0"}, 0, 1, 0, 0, 0, 0);
      st = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int k = 1; k <= len; k++) begin
         @(posedge clk); #1;
         mis = 1'b0;
         if (k % (h + 1) == 0) begin
            v   = k / (h + 1) - 1;
            mis = (b_tbl[v] != golden(v));
            err += int'(mis);
         end
         if (k < len) begin
            vec = k / (h + 1);
            check_outs(name, vec, 1, 0, 0, int'(mis), err);
         end else begin
            check_outs({name, ".end"}, 0, 0, 1, int'(err == 0), int'(mis), err);
         end
         st = (noisy && k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      repeat (3) begin
         @(posedge clk); #1;
         check_outs({name, ".hold"}, 0, 0, 1, int'(err == 0), 0, err);
      end
   endtask

   task automatic reset_mid(input int s);
      pulse_start(s);
      repeat (4 * (hold_of(s) + 1)) @(posedge clk);
      #1;
      check("rstmid.vec_before", o_vec, 4);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_outs("rstmid", 0, 0, 0, 0, 0, 0);
      repeat (5) begin
         @(posedge clk); #1;
         check_outs("rstmid.idle", 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      st    = 1'b0;
      sel   = 0;
      b_tbl = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset_h2", 0, 0, 0, 0, 0, 0);
      sel = 1; #1;
      check_outs("reset_h1", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      fill(0); run_sweep("h2_correct", 0, 1'b0);
      fill(1); run_sweep("h2_tied0", 0, 1'b1);
               run_sweep("h2_tied0_again", 0, 1'b0);
      fill(2); run_sweep("h2_tied1", 0, 1'b1);
      fill(3); run_sweep("h2_inverted", 0, 1'b0);
      for (int r = 0; r < 4; r++) begin
         fill(4); run_sweep("h2_random", 0, 1'b1);
      end
      fill(1); reset_mid(0);
      fill(0); run_sweep("h2_after_rst", 0, 1'b1);

      fill(0); run_sweep("h1_correct", 1, 1'b0);
      fill(3); run_sweep("h1_inverted", 1, 1'b1);
      for (int r = 0; r < 3; r++) begin
         fill(4); run_sweep("h1_random", 1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
